// File: rtl/rpn_engine.sv
// rpn_engine: postfix evaluation controller driving an external 8-bit stack.
// Optional build macro RPN_SATURATE_EN makes add/sub/mul saturate instead of wrap.
`default_nettype none

module rpn_engine #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             RstN,
  input  logic             Tok_Valid,
  output logic             Tok_Ready,
  input  logic             Tok_IsOp,
  input  logic [WIDTH-1:0] Tok_Data,
  output logic             Stk_Push,
  output logic             Stk_Pop,
  output logic [WIDTH-1:0] Stk_Din,
  input  logic [WIDTH-1:0] Stk_Dout,
  input  logic             Stk_Full,
  input  logic             Stk_Empty,
  output logic [WIDTH-1:0] Result,
  output logic             Result_Valid,
  output logic             Error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PUSH_V = 3'd1;
  localparam logic [2:0] S_POP_B  = 3'd2;
  localparam logic [2:0] S_CAP_B  = 3'd3;
  localparam logic [2:0] S_POP_A  = 3'd4;
  localparam logic [2:0] S_CAP_A  = 3'd5;
  localparam logic [2:0] S_PUSH_R = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_ILL = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  logic [2:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             push_q, push_d;
  logic             pop_q, pop_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rv_q, rv_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] alu_r;

  // A arrives on Stk_Dout during CAP_A, so it is used directly rather than stored.
`ifdef RPN_SATURATE_EN
  logic [WIDTH:0]     sum_w;
  logic [2*WIDTH-1:0] prod_w;
  assign sum_w  = {1'b0, Stk_Dout} + {1'b0, b_q};
  assign prod_w = {{WIDTH{1'b0}}, Stk_Dout} * {{WIDTH{1'b0}}, b_q};
`endif

  always_comb begin
    alu_r = '0;
    case (op_q)
`ifdef RPN_SATURATE_EN
      OP_ADD: alu_r = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
      OP_SUB: alu_r = (Stk_Dout < b_q) ? '0 : (Stk_Dout - b_q);
      OP_MUL: alu_r = (|prod_w[2*WIDTH-1:WIDTH]) ? '1 : prod_w[WIDTH-1:0];
`else
      OP_ADD: alu_r = Stk_Dout + b_q;
      OP_SUB: alu_r = Stk_Dout - b_q;
      OP_MUL: alu_r = Stk_Dout * b_q;
`endif
      OP_AND: alu_r = Stk_Dout & b_q;
      OP_OR:  alu_r = Stk_Dout | b_q;
      OP_XOR: alu_r = Stk_Dout ^ b_q;
      default: alu_r = '0;
    endcase
  end

  // Stack pulses are registered on the edge entering PUSH_*/POP_* states; the
  // full/empty flags cannot change between that edge and the state they guard.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_d      = b_q;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    din_d    = din_q;
    result_d = result_q;
    rv_d     = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (Tok_Valid) begin
          if (!Tok_IsOp) begin
            din_d   = Tok_Data;
            push_d  = !Stk_Full;
            state_d = S_PUSH_V;
          end else if (Tok_Data[2:0] == OP_ILL) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            op_d    = Tok_Data[2:0];
            pop_d   = !Stk_Empty;
            state_d = S_POP_B;
          end
        end
      end
      S_PUSH_V: begin
        if (Stk_Full) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_POP_B: begin
        if (Stk_Empty) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          state_d = S_CAP_B;
        end
      end
      S_CAP_B: begin
        b_d = Stk_Dout;
        if (op_q == OP_EQ) begin
          result_d = Stk_Dout;
          rv_d     = 1'b1;
          state_d  = S_IDLE;
        end else begin
          pop_d   = !Stk_Empty;
          state_d = S_POP_A;
        end
      end
      S_POP_A: begin
        if (Stk_Empty) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          state_d = S_CAP_A;
        end
      end
      S_CAP_A: begin
        din_d   = alu_r;
        push_d  = 1'b1;
        state_d = S_PUSH_R;
      end
      S_PUSH_R: state_d = S_IDLE;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      b_q      <= '0;
      push_q   <= 1'b0;
      pop_q    <= 1'b0;
      din_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_q      <= b_d;
      push_q   <= push_d;
      pop_q    <= pop_d;
      din_q    <= din_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
    end
  end

  assign Tok_Ready    = (state_q == S_IDLE);
  assign Stk_Push     = push_q;
  assign Stk_Pop      = pop_q;
  assign Stk_Din      = din_q;
  assign Result       = result_q;
  assign Result_Valid = rv_q;
  assign Error        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rpn_engine.sv
// tb_rpn_engine: drives rpn_engine against a behavioural 8-deep stack and checks
// every token against a queue-based RPN reference model with spec cycle timing.
`default_nettype none

module tb_rpn_engine;
  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic         Clk = 1'b0;
  logic         RstN;
  logic         Tok_Valid, Tok_Ready, Tok_IsOp;
  logic [W-1:0] Tok_Data;
  logic         Stk_Push, Stk_Pop;
  logic [W-1:0] Stk_Din, Stk_Dout;
  logic         Stk_Full, Stk_Empty;
  logic [W-1:0] Result;
  logic         Result_Valid, Error;

  rpn_engine #(.WIDTH(W)) dut (
    .Clk(Clk), .RstN(RstN),
    .Tok_Valid(Tok_Valid), .Tok_Ready(Tok_Ready), .Tok_IsOp(Tok_IsOp), .Tok_Data(Tok_Data),
    .Stk_Push(Stk_Push), .Stk_Pop(Stk_Pop), .Stk_Din(Stk_Din), .Stk_Dout(Stk_Dout),
    .Stk_Full(Stk_Full), .Stk_Empty(Stk_Empty),
    .Result(Result), .Result_Valid(Result_Valid), .Error(Error)
  );

  always #5 Clk = ~Clk;

  // Behavioural stack: popped word appears on Data_Out the cycle after Pop.
  logic [W-1:0] mem [DEPTH];
  logic [3:0]   stk_cnt;
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      stk_cnt  <= '0;
      Stk_Dout <= '0;
    end else if (Stk_Pop && stk_cnt != 0) begin
      Stk_Dout <= mem[stk_cnt-1];
      stk_cnt  <= stk_cnt - 1'b1;
    end else if (Stk_Push && stk_cnt != DEPTH) begin
      mem[stk_cnt[2:0]] <= Stk_Din;
      stk_cnt           <= stk_cnt + 1'b1;
    end
  end
  assign Stk_Full  = (stk_cnt == DEPTH);
  assign Stk_Empty = (stk_cnt == 0);

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  int ref_q[$];

  function automatic int ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
`ifdef RPN_SATURATE_EN
      0: r = (a + b > 255) ? 255 : a + b;
      1: r = (a < b) ? 0 : a - b;
      2: r = (a * b > 255) ? 255 : a * b;
`else
      0: r = (a + b) % 256;
      1: r = (a - b + 256) % 256;
      2: r = (a * b) % 256;
`endif
      3: r = a & b;
      4: r = a | b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  task automatic do_reset();
    @(negedge Clk);
    RstN = 1'b0;
    Tok_Valid = 1'b0;
    #1;
    check("rst_outputs_zero", {Stk_Push, Stk_Pop, Stk_Din, Result, Result_Valid, Error}, 0);
    @(negedge Clk);
    RstN = 1'b1;
    #1;
    check("rst_ready", Tok_Ready, 1);
    ref_q.delete();
    @(negedge Clk);
  endtask

  // Sends one token starting at a negedge and checks pulses by cycle offset from acceptance.
  task automatic send_tok(input bit is_op, input int val, input string name);
    bit exp_err = 0;
    int exp_end = 0, exp_push = 0, exp_pop = 0, exp_rvc = 0, exp_res = 0;
    int pm = 0, qm = 0, rvc = 0, res = 0, end_cyc = 0, both = 0, wt = 0, rdy_hi = 0;
    if (!is_op) begin
      if (ref_q.size() == DEPTH) begin exp_err = 1; exp_end = 2; end
      else begin exp_push = 1 << 1; exp_end = 2; ref_q.push_back(val); end
    end else if (val == 6) begin
      exp_err = 1; exp_end = 1;
    end else if (val == 7) begin
      if (ref_q.size() == 0) begin exp_err = 1; exp_end = 2; end
      else begin exp_pop = 1 << 1; exp_end = 3; exp_rvc = 3; exp_res = ref_q.pop_back(); end
    end else begin
      if (ref_q.size() == 0) begin exp_err = 1; exp_end = 2; end
      else if (ref_q.size() == 1) begin
        exp_err = 1; exp_end = 4; exp_pop = 1 << 1; void'(ref_q.pop_back());
      end else begin
        int b, a;
        b = ref_q.pop_back();
        a = ref_q.pop_back();
        ref_q.push_back(ref_alu(val, a, b));
        exp_pop = (1 << 1) | (1 << 3); exp_push = 1 << 5; exp_end = 6;
      end
    end

    Tok_Valid = 1'b1;
    Tok_IsOp  = is_op;
    Tok_Data  = is_op ? {W'($urandom_range(0, 31)) << 3} | W'(val) : W'(val);
    while (!Tok_Ready && wt < 50) begin @(negedge Clk); wt++; end
    if (!Tok_Ready) begin
      check({name, "_ready_wait"}, Tok_Ready, 1);
      Tok_Valid = 1'b0;
      return;
    end
    @(negedge Clk);
    Tok_Valid = 1'b0;
    Tok_Data  = W'($urandom);
    Tok_IsOp  = 1'($urandom);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (Stk_Push) pm |= 1 << cyc;
      if (Stk_Pop)  qm |= 1 << cyc;
      if (Stk_Push && Stk_Pop) both = 1;
      if (Result_Valid) begin rvc = cyc; res = Result; end
      if (Tok_Ready || Error) begin end_cyc = cyc; break; end
      @(negedge Clk);
    end
    check({name, "_end_cycle"}, end_cyc, exp_end);
    check({name, "_error"}, Error, exp_err);
    check({name, "_push_cycles"}, pm, exp_push);
    check({name, "_pop_cycles"}, qm, exp_pop);
    check({name, "_push_pop_excl"}, both, 0);
    check({name, "_rv_cycle"}, rvc, exp_rvc);
    if (is_op && val == 7 && !exp_err) check({name, "_result"}, res, exp_res);
    check({name, "_depth"}, stk_cnt, ref_q.size());
    if (exp_err) begin
      Tok_Valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(negedge Clk);
        if (Tok_Ready) rdy_hi++;
      end
      Tok_Valid = 1'b0;
      check({name, "_ready_in_err"}, rdy_hi, 0);
      check({name, "_error_sticky"}, Error, 1);
      do_reset();
    end
  endtask

  initial begin
    RstN = 1'b0;
    Tok_Valid = 1'b0;
    Tok_IsOp = 1'b0;
    Tok_Data = '0;
    repeat (2) @(negedge Clk);
    check("reset_outputs", {Stk_Push, Stk_Pop, Stk_Din, Result, Result_Valid, Error}, 0);
    RstN = 1'b1;
    @(negedge Clk);
    check("reset_ready", Tok_Ready, 1);

    send_tok(0, 3, "add_a"); send_tok(0, 4, "add_b"); send_tok(1, 0, "add_op");
    send_tok(1, 7, "add_eq");
    check("add_value", Result, 7);
    check("add_stack_empty", Stk_Empty, 1);

    send_tok(0, 3, "sub_a"); send_tok(0, 5, "sub_b"); send_tok(1, 1, "sub_op");
    send_tok(1, 7, "sub_eq");
`ifdef RPN_SATURATE_EN
    check("sub_value", Result, 0);
`else
    check("sub_value", Result, 254);
`endif

    send_tok(0, 20, "mul_a"); send_tok(0, 20, "mul_b"); send_tok(1, 2, "mul_op");
    send_tok(1, 7, "mul_eq");
`ifdef RPN_SATURATE_EN
    check("mul_value", Result, 255);
`else
    check("mul_value", Result, 144);
`endif

    send_tok(0, 7, "uflow_a"); send_tok(1, 0, "uflow_op");
    send_tok(1, 6, "illegal_op");
    for (int i = 1; i <= 9; i++) send_tok(0, i, "oflow_push");

    // Reset while the engine is in CAP_A of "2 3 *".
    send_tok(0, 2, "mid_a"); send_tok(0, 3, "mid_b");
    Tok_Valid = 1'b1; Tok_IsOp = 1'b1; Tok_Data = 8'd2;
    @(negedge Clk);
    Tok_Valid = 1'b0;
    repeat (3) @(negedge Clk);
    RstN = 1'b0;
    #1;
    check("mid_rst_outputs", {Stk_Push, Stk_Pop, Stk_Din, Result, Result_Valid, Error}, 0);
    check("mid_rst_stack", stk_cnt, 0);
    @(negedge Clk);
    RstN = 1'b1;
    ref_q.delete();
    @(negedge Clk);
    check("mid_rst_ready", Tok_Ready, 1);
    send_tok(0, 5, "post_a"); send_tok(1, 7, "post_eq");
    check("post_value", Result, 5);

    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) send_tok(1, 6, "rnd_ill");
      else if ((ref_q.size() < 2 && r >= 8) || r < 45) send_tok(0, $urandom_range(0, 255), "rnd_val");
      else if (r < 60) send_tok(1, 7, "rnd_eq");
      else send_tok(1, $urandom_range(0, 5), "rnd_bin");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/rpn_engine.md
# rpn_engine

Postfix (RPN) evaluation controller that sits directly upstream of the 8-bit `stack` block. It accepts a stream of operand and operator tokens over a valid/ready handshake and drives the stack's `Push`, `Pop` and `Data_In` pins. It reads popped values back from `Data_Out`, computes binary ALU results and pushes them back. On the `=` token it pops and presents the final result.

## Interface
- `WIDTH`, default 8: datapath width; must match the stack word width.
- `Clk`  in  1: rising-edge clock, shared with the stack.
- `RstN`  in  1: asynchronous, active-low reset.
- `Tok_Valid`  in  1: token present on `Tok_IsOp` and `Tok_Data`.
- `Tok_Ready`  out  1: engine can accept a token this cycle.
- `Tok_IsOp`  in  1: 1 means operator token, 0 means operand token.
- `Tok_Data`  in  WIDTH: operand value, or operator code in bits [2:0].
- `Stk_Push`  out  1: to stack `Push`; registered, one-cycle pulse.
- `Stk_Pop`  out  1: to stack `Pop`; registered, one-cycle pulse.
- `Stk_Din`  out  WIDTH: to stack `Data_In`; registered.
- `Stk_Dout`  in  WIDTH: from stack `Data_Out`.
- `Stk_Full`  in  1: from stack `Full`.
- `Stk_Empty`  in  1: from stack `Empty`.
- `Result`  out  WIDTH: last value popped by `=`.
- `Result_Valid`  out  1: one-cycle pulse when `Result` updates.
- `Error`  out  1: sticky overflow/underflow/illegal-op flag.

## Operation
- Stack contract: a `Stk_Pop` pulse in cycle k makes the popped word available on `Stk_Dout` in cycle k+1. `Stk_Empty` and `Stk_Full` reflect the state before the current edge.
- Operator codes:
  - 000 add, 001 sub (A−B), 010 mul (low WIDTH bits), 011 and, 100 or, 101 xor.
  - 110 is illegal and causes an error.
  - 111 is `=`.
  - B is the top of stack; A is the entry below it.
- FSM states: IDLE, PUSH_V, POP_B, CAP_B, POP_A, CAP_A, PUSH_R, ERR.
- IDLE: `Tok_Ready`=1. A handshake (`Tok_Valid`&&`Tok_Ready`) latches the token.
  - Operand → PUSH_V.
  - Binary op or `=` → POP_B.
  - Code 110 → ERR.
- PUSH_V:
  - If `Stk_Full` → ERR, with no push.
  - Else `Stk_Push`=1, `Stk_Din`=operand → IDLE.
- POP_B:
  - If `Stk_Empty` → ERR.
  - Else `Stk_Pop`=1 → CAP_B.
- CAP_B: B←`Stk_Dout`.
  - If op is `=`: `Result`←B, `Result_Valid` pulses next cycle, → IDLE.
  - Else → POP_A.
- POP_A: same empty check as POP_B → CAP_A.
- CAP_A: A←`Stk_Dout`, compute R → PUSH_R.
- PUSH_R: `Stk_Push`=1, `Stk_Din`=R → IDLE. Cannot overflow, because net depth has dropped by 1.
- ERR: `Error`=1, `Tok_Ready`=0. Stack pins are idle. The engine stays in ERR until reset.
- Arithmetic is modulo 2^WIDTH unless saturation is compiled in (see Configuration).
- Never assert `Stk_Push` and `Stk_Pop` in the same cycle.

## Timing
- Reset: state IDLE. `Tok_Ready`=1 after release. All other outputs are 0: `Stk_Push`, `Stk_Pop`, `Stk_Din`, `Result`, `Result_Valid`, `Error`.
- Operand accepted in cycle N:
  - `Stk_Push` asserted in N+1.
  - `Tok_Ready` high again in N+2.
- Binary operator accepted in cycle N:
  - `Stk_Pop` asserted in N+1 and N+3.
  - `Stk_Push` of the result asserted in N+5.
  - `Tok_Ready` high again in N+6.
- `=` accepted in cycle N:
  - `Stk_Pop` asserted in N+1.
  - `Result_Valid`=1 and `Result` updated in N+3.
  - `Tok_Ready` high in N+3.
- Underflow detected in POP_B or POP_A, or overflow in PUSH_V: `Error` rises in the next cycle. No stack pulse is issued.
- Reset mid-operation aborts immediately and returns all outputs to reset values. The stack shares `RstN`, so it is cleared as well.
- `Tok_Valid` may be held high while `Tok_Ready`=0. The token is consumed only on the handshake.

## Configuration
- Macro: `RPN_SATURATE_EN`.
- Defined:
  - add clamps to 2^WIDTH−1.
  - sub clamps to 0 on borrow.
  - mul clamps to 2^WIDTH−1 when the full product exceeds WIDTH bits.
- Undefined: all arithmetic wraps modulo 2^WIDTH.
- Logic ops are identical in both builds.

## Test plan
- Tokens 3, 4, `+`, `=` → `Result`=7 with `Result_Valid` pulse; `Error`=0; stack `Empty`=1 afterwards.
- Tokens 3, 5, `-`, `=` → `Result`=254 wrapping, or 0 with `RPN_SATURATE_EN`.
- Tokens 20, 20, `*`, `=` → `Result`=144 wrapping, or 255 with `RPN_SATURATE_EN`.
- Tokens 7, `+` → `Error`=1 after the second pop attempt; `Tok_Ready` stays 0 until `RstN` is pulsed low.
- Tokens 1 through 9 pushed into the stack with its default depth of 8, then `=` → `Error`=1 on the 9th push with no `Stk_Push` pulse.
- Assert `RstN`=0 during CAP_A of `2 3 *` → all outputs at reset values; after release, `5 =` gives `Result`=5.
